// File: rtl/prod_bcd_conv.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional build macro PROD_BCD_BLANK_EN replaces leading zero digits with 4'hF.
module prod_bcd_conv #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [WIDTH-1:0]      bin_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   bcd_o
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e                state_q;
   logic [WIDTH-1:0]      sr_q;
   logic [4*DIGITS-1:0]   scr_q;
   logic [4*DIGITS-1:0]   bcd_q;
   logic [CntW-1:0]       cnt_q;
   logic                  busy_q;
   logic                  done_q;

   logic [4*DIGITS-1:0]   scr_adj;
   logic [4*DIGITS-1:0]   scr_nxt;
   logic [WIDTH-1:0]      sr_nxt;
   logic [4*DIGITS-1:0]   bcd_fmt;
   logic                  lead;

   // Add-3 correction on every digit, then shift the whole {scratch, shiftreg} left by one.
   always_comb begin
      scr_adj = scr_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (scr_q[4*i +: 4] >= 4'd5) begin
            scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
         end
      end
      {scr_nxt, sr_nxt} = {scr_adj, sr_q} << 1;
   end

   always_comb begin
      bcd_fmt = scr_nxt;
      lead    = 1'b1;
`ifdef PROD_BCD_BLANK_EN
      // Blank from the top down until the first non-zero digit; digit 0 always shows.
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         if (lead && (scr_nxt[4*i +: 4] == 4'd0)) begin
            bcd_fmt[4*i +: 4] = 4'hF;
         end else begin
            lead = 1'b0;
         end
      end
`else
      lead = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sr_q    <= '0;
         scr_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  sr_q    <= bin_i;
                  scr_q   <= '0;
                  cnt_q   <= CntW'(WIDTH);
                  busy_q  <= 1'b1;
                  state_q <= StShift;
               end
            end
            StShift: begin
               sr_q  <= sr_nxt;
               scr_q <= scr_nxt;
               cnt_q <= cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  bcd_q   <= bcd_fmt;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDone: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign bcd_o  = bcd_q;

endmodule
